slsu: RTL and testbench

Load/store unit for the memory stage of the core. Accepts one load or store per handshake from the execute/memory pipeline and drives the data-memory request/grant/response port. Aligns and sign- or zero-extends load data. Presents the final loaded word to the write-back mux as its memory-data input.

---
 rtl/slsu_pkg.sv | 36 +++
 rtl/slsu_align.sv | 49 ++++
 rtl/slsu.sv | 132 +++++++++++++
 tb/tb_slsu.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/slsu_pkg.sv
// slsu shared types: funct3 width codes, FSM states
// and the request legality check.
package slsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    RESP
  } state_t;

  function automatic logic legal(
    input logic       we,
    input logic [2:0] f3,
    input logic [1:0] off
  );
    logic ok;
    logic mis;
    mis = (f3[1:0] == 2'b01 && off[0])
       || (f3[1:0] == 2'b10 && off != 2'b00);
    if (we)
      ok = (f3 == F3_B) || (f3 == F3_H)
        || (f3 == F3_W);
    else
      ok = (f3 == F3_B) || (f3 == F3_H)
        || (f3 == F3_W) || (f3 == F3_BU)
        || (f3 == F3_HU);
    return ok && !mis;
  endfunction

endpackage

// File: rtl/slsu_align.sv
// slsu lane logic: load byte/half extraction with
// extension, store data replication and byte enables.
module slsu_align
  import slsu_pkg::*;
(
  input  logic [2:0]  lfunct3,
  input  logic [1:0]  loffset,
  input  logic [31:0] rdata,
  output logic [31:0] ldata,
  input  logic [2:0]  sfunct3,
  input  logic [1:0]  soffset,
  input  logic [31:0] wdata,
  output logic [31:0] sdata,
  output logic [3:0]  sbe
);

  logic [7:0]  bsel;
  logic [15:0] hsel;

  always_comb begin
    bsel = rdata[{loffset, 3'b000} +: 8];
    hsel = loffset[1] ? rdata[31:16]
                      : rdata[15:0];
    unique case (lfunct3)
      F3_B:    ldata = {{24{bsel[7]}}, bsel};
      F3_BU:   ldata = {24'h0, bsel};
      F3_H:    ldata = {{16{hsel[15]}}, hsel};
      F3_HU:   ldata = {16'h0, hsel};
      default: ldata = rdata;
    endcase
  end

  always_comb begin
    sdata = wdata;
    sbe   = 4'b1111;
    unique case (sfunct3)
      F3_B: begin
        sdata = {4{wdata[7:0]}};
        sbe   = 4'b0001 << soffset;
      end
      F3_H: begin
        sdata = {2{wdata[15:0]}};
        sbe   = 4'b0011 << soffset;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/slsu.sv
// slsu: memory-stage load/store unit driving the
// data-memory req/gnt/rvalid port.
module slsu
  import slsu_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_we_i,
  input  logic [2:0]            req_funct3_i,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  input  logic [DATA_WIDTH-1:0] req_wdata_i,
  output logic                  done_o,
  output logic [DATA_WIDTH-1:0] load_data_o,
  output logic                  fault_o,
  output logic                  dmem_req_o,
  output logic                  dmem_we_o,
  output logic [ADDR_WIDTH-1:0] dmem_addr_o,
  output logic [3:0]            dmem_be_o,
  output logic [DATA_WIDTH-1:0] dmem_wdata_o,
  input  logic                  dmem_gnt_i,
  input  logic                  dmem_rvalid_i,
  input  logic [DATA_WIDTH-1:0] dmem_rdata_i
);

  state_t state, state_n;

  logic       op_we;
  logic [2:0] funct3_q;
  logic [1:0] off_q;
  logic       accept;
  logic       bad;

  logic [DATA_WIDTH-1:0] ldata;
  logic [DATA_WIDTH-1:0] sdata;
  logic [3:0]            sbe;

  slsu_align u_align (
    .lfunct3 (funct3_q),
    .loffset (off_q),
    .rdata   (dmem_rdata_i),
    .ldata   (ldata),
    .sfunct3 (req_funct3_i),
    .soffset (req_addr_i[1:0]),
    .wdata   (req_wdata_i),
    .sdata   (sdata),
    .sbe     (sbe)
  );

  assign req_ready_o = (state == IDLE);

  always_comb begin
    state_n = state;
    accept  = 1'b0;
    bad     = 1'b0;
    unique case (state)
      IDLE: begin
        if (req_valid_i) begin
          if (legal(req_we_i, req_funct3_i,
                    req_addr_i[1:0])) begin
            accept  = 1'b1;
            state_n = REQ;
          end else begin
            bad = 1'b1;
          end
        end
      end
      REQ: begin
        if (dmem_gnt_i)
          state_n = op_we ? IDLE : RESP;
      end
      RESP: begin
        if (dmem_rvalid_i)
          state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      op_we        <= 1'b0;
      funct3_q     <= 3'b000;
      off_q        <= 2'b00;
      done_o       <= 1'b0;
      fault_o      <= 1'b0;
      load_data_o  <= '0;
      dmem_req_o   <= 1'b0;
      dmem_we_o    <= 1'b0;
      dmem_addr_o  <= '0;
      dmem_be_o    <= 4'b0000;
      dmem_wdata_o <= '0;
    end else begin
      done_o  <= 1'b0;
      fault_o <= bad;
      if (accept) begin
        op_we        <= req_we_i;
        funct3_q     <= req_funct3_i;
        off_q        <= req_addr_i[1:0];
        dmem_req_o   <= 1'b1;
        dmem_we_o    <= req_we_i;
        dmem_addr_o  <= {req_addr_i[ADDR_WIDTH-1:2],
                         2'b00};
        dmem_be_o    <= req_we_i ? sbe : 4'b1111;
        dmem_wdata_o <= sdata;
      end
      if (state == REQ && dmem_gnt_i) begin
        dmem_req_o <= 1'b0;
        dmem_we_o  <= 1'b0;
        done_o     <= op_we;
      end
      // rvalid outside RESP is deliberately ignored
      if (state == RESP && dmem_rvalid_i) begin
        load_data_o <= ldata;
        done_o      <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_slsu.sv
// Directed self-checking bench for slsu.
// Inputs change and outputs are sampled 1ns after posedge.
module tb_slsu;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'b000;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        done;
  logic [31:0] load_data;
  logic        fault;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_gnt = 1'b0;
  logic        dmem_rvalid = 1'b0;
  logic [31:0] dmem_rdata = '0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  slsu dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .req_valid_i   (req_valid),
    .req_ready_o   (req_ready),
    .req_we_i      (req_we),
    .req_funct3_i  (req_funct3),
    .req_addr_i    (req_addr),
    .req_wdata_i   (req_wdata),
    .done_o        (done),
    .load_data_o   (load_data),
    .fault_o       (fault),
    .dmem_req_o    (dmem_req),
    .dmem_we_o     (dmem_we),
    .dmem_addr_o   (dmem_addr),
    .dmem_be_o     (dmem_be),
    .dmem_wdata_o  (dmem_wdata),
    .dmem_gnt_i    (dmem_gnt),
    .dmem_rvalid_i (dmem_rvalid),
    .dmem_rdata_i  (dmem_rdata)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h",
               tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic we,
                         input logic [2:0] f3,
                         input logic [31:0] a,
                         input logic [31:0] wd);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = wd;
  endtask

  // accept, grant at T+1, rvalid at T+2
  task automatic do_load(input string tag,
                         input logic [2:0] f3,
                         input logic [31:0] a,
                         input logic [31:0] rd,
                         input logic [31:0] exp);
    present(1'b0, f3, a, '0);
    step();
    req_valid = 1'b0;
    chk({tag, ".req"}, 32'(dmem_req), 32'd1);
    chk({tag, ".addr"}, dmem_addr,
        {a[31:2], 2'b00});
    chk({tag, ".be"}, 32'(dmem_be), 32'hf);
    chk({tag, ".rdy"}, 32'(req_ready), 32'd0);
    dmem_gnt = 1'b1;
    step();
    dmem_gnt = 1'b0;
    chk({tag, ".req0"}, 32'(dmem_req), 32'd0);
    chk({tag, ".nodone"}, 32'(done), 32'd0);
    dmem_rvalid = 1'b1;
    dmem_rdata  = rd;
    step();
    dmem_rvalid = 1'b0;
    chk({tag, ".done"}, 32'(done), 32'd1);
    chk({tag, ".data"}, load_data, exp);
  endtask

  initial begin
    step();
    step();
    chk("rst.req", 32'(dmem_req), 32'd0);
    chk("rst.done", 32'(done), 32'd0);
    chk("rst.ld", load_data, 32'd0);
    chk("rst.rdy", 32'(req_ready), 32'd1);
    rst = 1'b0;
    step();

    do_load("lw", 3'b010, 32'h100,
            32'hDEADBEEF, 32'hDEADBEEF);
    step();
    chk("lw.pulse", 32'(done), 32'd0);
    do_load("lb", 3'b000, 32'h103,
            32'h80112233, 32'hFFFFFF80);
    do_load("lbu", 3'b100, 32'h103,
            32'h80112233, 32'h00000080);
    do_load("lhu", 3'b101, 32'h102,
            32'h80112233, 32'h00008011);
    do_load("lh", 3'b001, 32'h100,
            32'h1234F00D, 32'hFFFFF00D);
    step();

    // SH with 3-cycle grant delay
    present(1'b1, 3'b001, 32'h206, 32'h0000ABCD);
    step();
    req_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("sh.req", 32'(dmem_req), 32'd1);
      chk("sh.we", 32'(dmem_we), 32'd1);
      chk("sh.addr", dmem_addr, 32'h204);
      chk("sh.be", 32'(dmem_be), 32'hc);
      chk("sh.wd", dmem_wdata, 32'hABCDABCD);
      chk("sh.nodone", 32'(done), 32'd0);
      step();
    end
    dmem_gnt = 1'b1;
    chk("sh.req3", 32'(dmem_req), 32'd1);
    step();
    dmem_gnt = 1'b0;
    chk("sh.done", 32'(done), 32'd1);
    chk("sh.req0", 32'(dmem_req), 32'd0);
    step();
    chk("sh.pulse", 32'(done), 32'd0);

    // SB offset 1
    present(1'b1, 3'b000, 32'h41, 32'h000000AB);
    step();
    req_valid = 1'b0;
    chk("sb.be", 32'(dmem_be), 32'h2);
    chk("sb.wd", dmem_wdata, 32'hABABABAB);
    chk("sb.addr", dmem_addr, 32'h40);
    dmem_gnt = 1'b1;
    step();
    dmem_gnt = 1'b0;
    chk("sb.done", 32'(done), 32'd1);

    // faults back to back, then a legal LW
    present(1'b0, 3'b010, 32'h101, '0);
    step();
    chk("f1.fault", 32'(fault), 32'd1);
    chk("f1.req", 32'(dmem_req), 32'd0);
    chk("f1.rdy", 32'(req_ready), 32'd1);
    present(1'b1, 3'b011, 32'h100, 32'h5);
    step();
    chk("f2.fault", 32'(fault), 32'd1);
    chk("f2.req", 32'(dmem_req), 32'd0);
    present(1'b0, 3'b010, 32'h108, '0);
    step();
    req_valid = 1'b0;
    chk("f3.fault", 32'(fault), 32'd0);
    chk("f3.req", 32'(dmem_req), 32'd1);
    chk("f3.addr", dmem_addr, 32'h108);
    dmem_gnt = 1'b1;
    step();
    dmem_gnt    = 1'b0;
    dmem_rvalid = 1'b1;
    dmem_rdata  = 32'h0BADF00D;
    step();
    dmem_rvalid = 1'b0;
    chk("f3.done", 32'(done), 32'd1);
    chk("f3.data", load_data, 32'h0BADF00D);

    // reset while in RESP
    present(1'b0, 3'b010, 32'h200, '0);
    step();
    req_valid = 1'b0;
    dmem_gnt  = 1'b1;
    step();
    dmem_gnt = 1'b0;
    rst = 1'b1;
    #1;
    chk("rr.rdy", 32'(req_ready), 32'd1);
    chk("rr.req", 32'(dmem_req), 32'd0);
    chk("rr.addr", dmem_addr, 32'd0);
    chk("rr.ld", load_data, 32'd0);
    step();
    rst = 1'b0;
    dmem_rvalid = 1'b1;
    dmem_rdata  = 32'h11111111;
    step();
    dmem_rvalid = 1'b0;
    chk("rr.done", 32'(done), 32'd0);
    chk("rr.ld2", load_data, 32'd0);

    // SW accepted in the load's done cycle
    do_load("bb", 3'b010, 32'h300,
            32'h12345678, 32'h12345678);
    chk("bb.rdy", 32'(req_ready), 32'd1);
    present(1'b1, 3'b010, 32'h304, 32'hCAFEF00D);
    step();
    req_valid = 1'b0;
    chk("bb.req", 32'(dmem_req), 32'd1);
    chk("bb.we", 32'(dmem_we), 32'd1);
    chk("bb.be", 32'(dmem_be), 32'hf);
    chk("bb.wd", dmem_wdata, 32'hCAFEF00D);
    chk("bb.ld", load_data, 32'h12345678);
    dmem_gnt = 1'b1;
    step();
    dmem_gnt = 1'b0;
    chk("bb.done", 32'(done), 32'd1);
    chk("bb.ld2", load_data, 32'h12345678);
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
